// File: rtl/bcd_sub_serial_if.sv
// Handshake and operand/result bus for the digit-serial BCD subtractor.
interface bcd_sub_serial_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow;
  logic                  err;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, err
  );
endinterface

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: diff = (A - B) mod 10^DIGITS, one digit per
// clock, LSB digit first, with a borrow chain and a start/busy/done handshake.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_sub_serial_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res_sh;
  logic [CW-1:0] cnt;
  logic          borrow_int;
  logic          err_int;

  logic [W-1:0]  diff_q;
  logic          borrow_q;
  logic          err_q;

  logic [3:0]        a_k;
  logic [3:0]        b_k;
  logic signed [4:0] t;
  logic [3:0]        dig;
  logic              borrow_nx;
  logic              err_nx;
  logic [W-1:0]      res_nx;

  // Per-digit subtract with borrow; result digit enters the result register at the MSB side
  always_comb begin
    a_k       = a_sh[3:0];
    b_k       = b_sh[3:0];
    t         = $signed({1'b0, a_k}) - $signed({1'b0, b_k}) - $signed({4'd0, borrow_int});
    borrow_nx = t[4];
    dig       = borrow_nx ? 4'(t + 5'sd10) : t[3:0];
    err_nx    = err_int | (a_k > 4'd9) | (b_k > 4'd9);
    // Shift of the concatenation keeps this valid for DIGITS=1 (no empty slice)
    res_nx    = W'({dig, res_sh} >> 4);
  end

  // Control FSM, operand shifters, borrow chain and held result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      borrow_int <= 1'b0;
      err_int    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            res_sh     <= '0;
            cnt        <= '0;
            borrow_int <= 1'b0;
            err_int    <= 1'b0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh       <= a_sh >> 4;
          b_sh       <= b_sh >> 4;
          res_sh     <= res_nx;
          borrow_int <= borrow_nx;
          err_int    <= err_nx;
          cnt        <= cnt + CW'(1);
          if (cnt == LAST) begin
            state    <= S_DONE;
            diff_q   <= err_nx ? '0 : res_nx;
            borrow_q <= borrow_nx & ~err_nx;
            err_q    <= err_nx;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (state == S_RUN);
  assign bus.done   = (state == S_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// Bench for bcd_sub_serial: vector table through a result scoreboard, plus
// hand sequences for held start, mid-operation start pulses and reset abort.
module tb_bcd_sub_serial;
  localparam int DIGITS = 4;
  localparam int NVEC   = 10;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bo;
    logic        e;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t got;

  bcd_sub_serial_if #(.DIGITS(DIGITS)) bus ();

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: bench did not complete");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got diff=%h borrow=%b err=%b, required no done", bus.diff, bus.borrow, bus.err);
      end else begin
        got = sb.pop_front();
        if (bus.diff !== got.d || bus.borrow !== got.bo || bus.err !== got.e) begin
          n_bad++;
          $display("FAIL result: got diff=%h borrow=%b err=%b, required diff=%h borrow=%b err=%b",
                   bus.diff, bus.borrow, bus.err, got.d, got.bo, got.e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One operation; poke adds stray start pulses during RUN and DONE
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ed,
                        input logic eb, input logic ee, input bit poke);
    int busy_cnt;
    exp_t x;
    busy_cnt = 0;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    x.d = ed; x.bo = eb; x.e = ee;
    sb.push_back(x);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
      end
      if (poke && i == 1) bus.start = 1'b1;
      if (poke && i == 2) bus.start = 1'b0;
      if (bus.busy && !bus.done) busy_cnt++;
    end
    @(negedge clk);
    check("latency", {busy_cnt[29:0], bus.busy, bus.done}, {30'(DIGITS), 1'b0, 1'b1});
    if (poke) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  vec_t tbl[NVEC];
  int   seen;

  initial begin
    tbl[0] = '{16'h5234, 16'h1789, 16'h3445, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0};
    tbl[2] = '{16'h1000, 16'h0999, 16'h0001, 1'b0, 1'b0};
    tbl[3] = '{16'h4747, 16'h4747, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{16'h0050, 16'h0025, 16'h0025, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h9999, 16'h0001, 1'b1, 1'b0};
    tbl[7] = '{16'h9999, 16'h0001, 16'h9998, 1'b0, 1'b0};
    tbl[8] = '{16'h0000, 16'h00F0, 16'h0000, 1'b0, 1'b1};
    tbl[9] = '{16'h0500, 16'h0501, 16'h9999, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {11'd0, bus.busy, bus.done, bus.diff, bus.borrow, bus.err}, 32'd0);

    // Table vectors, each started in the first IDLE cycle after the previous done
    for (int i = 0; i < NVEC; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].e, 1'b0);

    // Results hold between done pulses
    repeat (3) @(negedge clk);
    check("hold", {15'd0, bus.diff, bus.borrow}, {15'd0, 16'h9999, 1'b1});

    // start held high: one operation per DIGITS+2 cycles, two accepted here
    @(negedge clk);
    bus.a = 16'h0321;
    bus.b = 16'h0123;
    bus.start = 1'b1;
    sb.push_back('{16'h0198, 1'b0, 1'b0});
    sb.push_back('{16'h0198, 1'b0, 1'b0});
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    bus.start = 1'b0;
    check("held_start_dones", 32'(seen), 32'd2);
    repeat (3) @(negedge clk);

    // Stray start pulses in RUN and DONE are ignored
    run_op(16'h8000, 16'h0001, 16'h7999, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);

    // Reset during the second RUN cycle aborts without a done
    @(negedge clk);
    bus.a = 16'h2222;
    bus.b = 16'h1111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {11'd0, bus.busy, bus.done, bus.diff, bus.borrow, bus.err}, 32'd0);
    repeat (8) @(negedge clk);
    run_op(16'h0050, 16'h0025, 16'h0025, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_sub_serial.md
Name: bcd_sub_serial

Overview:
Digit-serial BCD subtractor: computes A − B over DIGITS packed BCD digits, one digit per clock, LSB digit first, with a borrow chain.
- It is the inverse-direction companion of the combinational two-digit BCD adder.
- Used wherever multi-digit decimal differences are needed at low area, e.g. counters, timers and display arithmetic.
- Uses a start/busy/done handshake; results are registered and held until the next operation completes.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1); operand width 4*DIGITS.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  minuend, packed BCD, digit 0 = a[3:0]
b  input  4*DIGITS  subtrahend, packed BCD, same packing
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse, results valid from this cycle
diff  output  4*DIGITS  (A − B) mod 10^DIGITS, packed BCD
borrow  output  1  1 when A < B (diff is then the ten's complement)
err  output  1  1 when any captured digit of a or b was > 9

Behaviour:
Interface:
- One clock (clk).
- Reset rst is synchronous and active-high.

Reset:
- On any rising edge with rst=1, the FSM goes to IDLE.
- busy=0, done=0, diff=0, borrow=0, err=0.
- Internal operand registers, digit counter and borrow are cleared.
- Reset has priority over start and aborts an operation in progress; no done pulse follows an aborted operation.

FSM states: IDLE, RUN, DONE.

IDLE:
- If start=1 at an edge: capture a and b into shift registers, set digit counter=0, clear borrow_int and err_int, go to RUN.
- Otherwise stay in IDLE.

RUN (busy=1):
- Each edge processes digit k = counter.
- Compute t = a_k − b_k − borrow_int using a 5-bit signed value.
- If t < 0: digit = t + 10 and borrow_int = 1; else digit = t and borrow_int = 0.
- If a_k > 9 or b_k > 9: set err_int.
- Shift the result digit into the result register from the MSB side, so that after DIGITS shifts digit 0 sits at bits [3:0].
- After the edge that processes digit DIGITS−1, go to DONE.

DONE (busy=0, done=1 for exactly one cycle):
- diff, borrow and err are loaded at the edge entering DONE.
- If err_int=1: diff=0 and borrow=0 regardless of the computed result.
- The next edge returns the FSM to IDLE; done drops.

Latency and handshake:
- If start is sampled at edge E0, busy is high for the DIGITS cycles that follow.
- done is high in the cycle after edge E_DIGITS.
- A new start is accepted no earlier than the IDLE cycle after done, i.e. a throughput of one operation per DIGITS+2 cycles.
- start is ignored in RUN and in DONE: no restart, and no queuing of the request.
- a and b may change freely after the capture edge.

Output holding:
- diff, borrow and err hold their values between done pulses.
- They change only at the edge entering DONE, or on reset.

Boundary cases:
- Equal operands give diff=0 and borrow=0.
- 0 − 1 gives all digits 9 and borrow=1.
- Borrow out of the MSB digit appears only on the borrow output; diff wraps modulo 10^DIGITS.

Test Plan:
- DIGITS=4, a=16'h5234, b=16'h1789, start pulse. Expected: busy high for exactly 4 cycles, done 4 cycles after the start edge, diff=16'h3445, borrow=0, err=0.
- a=16'h0000, b=16'h0001. Expected: diff=16'h9999, borrow=1. Then a=16'h1000, b=16'h0999. Expected: diff=16'h0001, borrow=0; this exercises the full-length borrow ripple.
- a=b=16'h4747. Expected: diff=16'h0000, borrow=0. Follow back-to-back with a start in the first IDLE cycle after done; the second operation must complete correctly.
- a=16'h12A4 (invalid digit A). Expected: err=1, diff=0, borrow=0 at done. The next valid operation, 16'h0050 − 16'h0025, must clear err and give diff=16'h0025.
- Hold start=1 continuously, and pulse start again during RUN and during DONE. Expected: exactly one done per accepted request, and the result is unaffected by the mid-operation pulses.
- Assert rst for one cycle during the 2nd RUN cycle. Expected: the next cycle shows busy=0, done=0 and all outputs 0, and no done follows; a subsequent start then operates normally.
